// File: rtl/fp_multiply_pipe_if.sv
// Valid/ready stream bundle for the custom-float multiplier: operand side and result side.
interface fp_multiply_pipe_if #(
   parameter int W = 27
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] input_a;
   logic [W-1:0] input_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] output_q;
   logic         underflow;
   logic         overflow;

   modport master (
      output in_valid, input_a, input_b, out_ready,
      input  in_ready, out_valid, output_q, underflow, overflow
   );

   modport slave (
      input  in_valid, input_a, input_b, out_ready,
      output in_ready, out_valid, output_q, underflow, overflow
   );
endinterface

// File: rtl/fp_multiply_pipe.sv
// Three-stage custom-float multiplier {sign, exponent, 0.M with explicit leading 1}
// with a single global stall, round-half-up and flush/saturate on exponent range.
module fp_multiply_pipe #(
   parameter int EXPONENT_WIDTH = 8,
   parameter int MANTISSA_WIDTH = 18,
   parameter int BIAS           = 127,
   parameter int ROUND_NEAREST  = 1
) (
   input logic               clk,
   input logic               rst,
   fp_multiply_pipe_if.slave bus
);
   localparam int EW = EXPONENT_WIDTH;
   localparam int MW = MANTISSA_WIDTH;
   localparam int W  = 1 + EW + MW;
   localparam int PW = 2 * MW;
   localparam int TW = MW + 2;
   localparam int XW = EW + 2;
   localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** EW) - 1);
   localparam logic signed [XW-1:0] BIAS_X  = XW'(BIAS);
   localparam logic signed [XW-1:0] ONE_X   = XW'(1);
   localparam logic        [MW:0]   ONE_R   = (MW + 1)'(1);

   logic                 advance;
   logic                 vld_p1, vld_p2, vld_p3;
   logic [EW-1:0]        ea, eb;
   logic [MW-1:0]        ma_in, mb_in;
   logic signed [XW-1:0] esum_in;

   logic [MW-1:0]        ma_p1, mb_p1;
   logic                 zero_p1, sign_p1;
   logic signed [XW-1:0] esum_p1;

   logic [TW-1:0]        prod_p2;
   logic                 zero_p2, sign_p2;
   logic signed [XW-1:0] esum_p2;

   logic [MW-1:0]        m_norm, m_rnd;
   logic                 rbit;
   logic [MW:0]          m_r;
   logic signed [XW-1:0] e_norm, e_rnd;
   logic [W+1:0]         res_s3;

   logic [W-1:0]         q_p3;
   logic                 uf_p3, of_p3;

   function automatic logic [MW:0] round_mant(input logic [MW-1:0] m, input logic r);
      logic [MW:0] acc;
      acc = {1'b0, m};
      if ((ROUND_NEAREST != 0) && r) acc = acc + ONE_R;
      return acc;
   endfunction

   // Returns {underflow, overflow, word}.
   function automatic logic [W+1:0] saturate(input logic s, input logic z,
                                             input logic signed [XW-1:0] e,
                                             input logic [MW-1:0] m);
      if (z)                return '0;
      else if (e[XW-1])     return {2'b10, {W{1'b0}}};
      else if (e > EXP_MAX) return {2'b01, s, {(W-1){1'b1}}};
      else                  return {2'b00, s, e[EW-1:0], m};
   endfunction

   assign ea      = bus.input_a[MW +: EW];
   assign eb      = bus.input_b[MW +: EW];
   assign ma_in   = bus.input_a[MW-1:0];
   assign mb_in   = bus.input_b[MW-1:0];
   assign esum_in = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;

   assign advance      = !vld_p3 || bus.out_ready;
   assign bus.in_ready = advance;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
      end else if (advance) begin
         vld_p1 <= bus.in_valid;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
      end
   end

   // S1: operand capture, zero detect, sign and biased exponent sum
   always_ff @(posedge clk) begin
      if (advance) begin
         ma_p1   <= ma_in;
         mb_p1   <= mb_in;
         zero_p1 <= (ma_in == '0) || (mb_in == '0);
         sign_p1 <= bus.input_a[W-1] ^ bus.input_b[W-1];
         esum_p1 <= esum_in;
      end
   end

   // S2: mantissa product; only P[2MW-1:MW-2] feeds normalise/round, so only those bits are kept
   always_ff @(posedge clk) begin
      if (advance) begin
         prod_p2 <= TW'((PW'(ma_p1) * PW'(mb_p1)) >> (MW - 2));
         zero_p2 <= zero_p1;
         sign_p2 <= sign_p1;
         esum_p2 <= esum_p1;
      end
   end

   // S3: normalise on the product MSB, round, then flush/saturate
   always_comb begin
      if (prod_p2[TW-1]) begin
         m_norm = prod_p2[TW-1:2];
         rbit   = prod_p2[1];
         e_norm = esum_p2;
      end else begin
         m_norm = prod_p2[TW-2:1];
         rbit   = prod_p2[0];
         e_norm = esum_p2 - ONE_X;
      end
      m_r = round_mant(m_norm, rbit);
      if (m_r[MW]) begin
         m_rnd = {1'b1, {(MW-1){1'b0}}};
         e_rnd = e_norm + ONE_X;
      end else begin
         m_rnd = m_r[MW-1:0];
         e_rnd = e_norm;
      end
      res_s3 = saturate(sign_p2, zero_p2, e_rnd, m_rnd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_p3  <= '0;
         uf_p3 <= 1'b0;
         of_p3 <= 1'b0;
      end else if (advance && vld_p2) begin
         uf_p3 <= res_s3[W+1];
         of_p3 <= res_s3[W];
         q_p3  <= res_s3[W-1:0];
      end
   end

   assign bus.out_valid = vld_p3;
   assign bus.output_q  = q_p3;
   assign bus.underflow = uf_p3;
   assign bus.overflow  = of_p3;
endmodule

// File: tb/tb_fp_multiply_pipe.sv
// Directed bench for fp_multiply_pipe: arithmetic vectors, limits, backpressure and mid-flight reset.
module tb_fp_multiply_pipe;
   localparam int W = 27;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fp_multiply_pipe_if #(.W(W)) bus   ();
   fp_multiply_pipe_if #(.W(W)) bus_t ();

   assign bus_t.in_valid  = bus.in_valid;
   assign bus_t.input_a   = bus.input_a;
   assign bus_t.input_b   = bus.input_b;
   assign bus_t.out_ready = bus.out_ready;

   fp_multiply_pipe #(.ROUND_NEAREST(1)) dut   (.clk(clk), .rst(rst), .bus(bus));
   fp_multiply_pipe #(.ROUND_NEAREST(0)) dut_t (.clk(clk), .rst(rst), .bus(bus_t));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.input_a  = a;
      bus.input_b  = b;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
      check("result_timeout", 32'(bus.out_valid), 32'd1);
   endtask

   logic [W-1:0] exp_q [6];
   logic [W-1:0] got [$];
   logic [W-1:0] held;
   int           sent;
   int           extra;

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.input_a   = '0;
      bus.input_b   = '0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_output_q",  32'(bus.output_q),  32'd0);
      check("rst_underflow", 32'(bus.underflow), 32'd0);
      check("rst_overflow",  32'(bus.overflow),  32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      rst = 1'b0;
      tick();

      // 1.0 * 1.0 with latency: accept edge plus two more edges
      bus.input_a  = 27'h2020000;
      bus.input_b  = 27'h2020000;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      check("lat_early", 32'(bus.out_valid), 32'd0);
      tick();
      check("lat_valid", 32'(bus.out_valid), 32'd1);
      check("one_q",     32'(bus.output_q),  32'h2020000);
      check("one_uf",    32'(bus.underflow), 32'd0);
      check("one_of",    32'(bus.overflow),  32'd0);
      tick();

      // -1.5 * 2.0 = -3.0 = -0.75 * 2^2
      run_op(27'h6030000, 27'h2060000);
      check("neg_q", 32'(bus.output_q), 32'h6070000);

      run_op(27'h2030001, 27'h2030001);
      check("round_near_q",  32'(bus.output_q),   32'h2064002);
      check("round_trunc_q", 32'(bus_t.output_q), 32'h2064001);

      run_op(27'h2020000, 27'h3FC0000);
      check("zero_q",  32'(bus.output_q),  32'd0);
      check("zero_uf", 32'(bus.underflow), 32'd0);
      check("zero_of", 32'(bus.overflow),  32'd0);

      run_op(27'h0420000, 27'h0420000);
      check("uf_q",    32'(bus.output_q),  32'd0);
      check("uf_flag", 32'(bus.underflow), 32'd1);
      check("uf_of",   32'(bus.overflow),  32'd0);

      run_op(27'h3C20000, 27'h3C20000);
      check("of_q",    32'(bus.output_q),  32'h3FFFFFF);
      check("of_flag", 32'(bus.overflow),  32'd1);
      check("of_uf",   32'(bus.underflow), 32'd0);

      // Result exponent 0 is a normal number; flags from the previous result clear
      run_op(27'h1020000, 27'h1020000);
      check("e0_q",  32'(bus.output_q),  32'h0020000);
      check("e0_uf", 32'(bus.underflow), 32'd0);
      check("e0_of", 32'(bus.overflow),  32'd0);

      run_op(27'h2FF0000, 27'h2FF0000);
      check("emax_q",  32'(bus.output_q), 32'h3FE4000);
      check("emax_of", 32'(bus.overflow), 32'd0);
      tick();

      // Backpressure: 1.0 * b_i = b_i, consumer blocked for 4 cycles
      for (int i = 0; i < 6; i++) exp_q[i] = W'(32'h2030000 + 32'(i) * 32'h40000);
      sent = 0;
      held = '0;
      got.delete();
      for (int c = 0; c < 60 && got.size() < 6; c++) begin
         bus.out_ready = !(c >= 3 && c < 7);
         bus.in_valid  = (sent < 6);
         bus.input_a   = 27'h2020000;
         bus.input_b   = exp_q[(sent < 6) ? sent : 0];
         #1;
         if (c == 3) held = bus.output_q;
         if (c == 5) begin
            check("stall_in_ready", 32'(bus.in_ready),  32'd0);
            check("stall_valid",    32'(bus.out_valid), 32'd1);
            check("stall_hold",     32'(bus.output_q),  32'(held));
         end
         if (bus.out_valid && bus.out_ready) got.push_back(bus.output_q);
         if (bus.in_valid && bus.in_ready) sent++;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.out_valid) extra++;
         tick();
      end
      check("bp_count", 32'(got.size()), 32'd6);
      check("bp_extra", 32'(extra),      32'd0);
      for (int i = 0; i < 6; i++)
         check($sformatf("bp_res%0d", i), 32'((got.size() > i) ? got[i] : '1), 32'(exp_q[i]));

      // Reset with three operations in flight
      bus.input_a  = 27'h2020000;
      bus.input_b  = 27'h2020000;
      bus.in_valid = 1'b1;
      tick();
      tick();
      tick();
      bus.in_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("rst_flight_valid", 32'(bus.out_valid), 32'd0);
      rst = 1'b0;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         if (bus.out_valid) extra++;
         tick();
      end
      check("rst_no_stale", 32'(extra), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
